// File: rtl/hazard_scoreboard_pkg.sv
// Shared types, forwarding-select encodings and sizing helpers for the hazard scoreboard.
package hazard_scoreboard_pkg;

    // Entries carry a fixed-width destination so one struct serves every REG_ADDR_W up to 8.
    localparam int SB_DST_W = 8;

    localparam int FWD_RF  = 0;
    localparam int FWD_MEM = 1;

    function automatic int fwd_wb(input int mem_lat);
        return mem_lat + 1;
    endfunction

    function automatic int sel_width(input int mem_lat);
        return $clog2(mem_lat + 3);
    endfunction

    typedef struct packed {
        logic                valid;
        logic [SB_DST_W-1:0] dst;
        logic                wb_en;
        logic                mem_read;
    } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-side request and hazard/forwarding response bundle of the hazard scoreboard.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_W = 4,
    parameter int SEL_W      = 2,
    parameter int CNT_W      = 32
);
    logic                  fwd_enable;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_src1;
    logic [REG_ADDR_W-1:0] id_src2;
    logic                  id_has_src1;
    logic                  id_has_src2;
    logic [REG_ADDR_W-1:0] id_dst;
    logic                  id_wb_en;
    logic                  id_mem_read;
    logic                  flush;
    logic                  stall;
    logic [SEL_W-1:0]      fwd_sel1;
    logic [SEL_W-1:0]      fwd_sel2;
    logic [CNT_W-1:0]      stall_count;

    modport master (
        output fwd_enable, id_valid, id_src1, id_src2, id_has_src1, id_has_src2,
               id_dst, id_wb_en, id_mem_read, flush,
        input  stall, fwd_sel1, fwd_sel2, stall_count
    );

    modport slave (
        input  fwd_enable, id_valid, id_src1, id_src2, id_has_src1, id_has_src2,
               id_dst, id_wb_en, id_mem_read, flush,
        output stall, fwd_sel1, fwd_sel2, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard_sb_match.sv
// Compares one ID source against the comparable scoreboard entries (EXE and MEM slots).
module sb_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int NCMP    = 2,
    parameter int MEM_LAT = 1,
    parameter int IDX_W   = 2
) (
    input  logic                  req_i,
    input  logic [SB_DST_W-1:0]   src_i,
    input  sb_entry_t [NCMP-1:0]  ent_i,
    output logic                  hit_o,
    output logic [IDX_W-1:0]      idx_o,
    output logic                  ld_haz_o
);

    // Scan oldest to youngest so the lowest matching index is the one left in idx_o.
    always_comb begin
        hit_o    = 1'b0;
        idx_o    = '0;
        ld_haz_o = 1'b0;
        for (int j = NCMP - 1; j >= 0; j--) begin
            if (req_i && ent_i[j].valid && ent_i[j].wb_en && ent_i[j].dst == src_i) begin
                hit_o = 1'b1;
                idx_o = IDX_W'(j);
                if (ent_i[j].mem_read && j < MEM_LAT) ld_haz_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding control between ID and EXE, tracking in-flight
// destinations over EXE, MEM_LAT memory slots and WB.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter  int REG_ADDR_W = 4,
    parameter  int MEM_LAT    = 1,
    parameter  int CNT_W      = 32,
    localparam int DEPTH      = MEM_LAT + 2,
    localparam int SEL_W      = sel_width(MEM_LAT)
) (
    input logic clk,
    input logic rst,
    hazard_scoreboard_if.slave bus
);

    sb_entry_t [DEPTH-1:0] sb_q, sb_d;
    sb_entry_t             ent_new;
    logic [SEL_W-1:0]      sel1_q, sel1_d, sel2_q, sel2_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  hit1, hit2, ldh1, ldh2;
    logic [SEL_W-1:0]      idx1, idx2;
    logic                  stall, issue;

    // WB (last entry) is left out: the register file writes before it reads.
    sb_match #(.NCMP(DEPTH - 1), .MEM_LAT(MEM_LAT), .IDX_W(SEL_W)) u_match1 (
        .req_i   (bus.id_valid & bus.id_has_src1),
        .src_i   (SB_DST_W'(REG_ADDR_W'(bus.id_src1))),
        .ent_i   (sb_q[DEPTH-2:0]),
        .hit_o   (hit1),
        .idx_o   (idx1),
        .ld_haz_o(ldh1)
    );

    sb_match #(.NCMP(DEPTH - 1), .MEM_LAT(MEM_LAT), .IDX_W(SEL_W)) u_match2 (
        .req_i   (bus.id_valid & bus.id_has_src2),
        .src_i   (SB_DST_W'(REG_ADDR_W'(bus.id_src2))),
        .ent_i   (sb_q[DEPTH-2:0]),
        .hit_o   (hit2),
        .idx_o   (idx2),
        .ld_haz_o(ldh2)
    );

    always_comb begin
        stall = !rst && !bus.flush && (bus.fwd_enable ? (ldh1 || ldh2) : (hit1 || hit2));
        issue = bus.id_valid && !stall && !bus.flush;

        ent_new = '0;
        if (issue) begin
            ent_new.valid    = 1'b1;
            ent_new.dst      = SB_DST_W'(REG_ADDR_W'(bus.id_dst));
            ent_new.wb_en    = bus.id_wb_en;
            ent_new.mem_read = bus.id_mem_read;
        end
        sb_d = {sb_q[DEPTH-2:0], ent_new};

        // The matched producer moves one slot older at the edge, hence the +1.
        sel1_d = (issue && bus.fwd_enable && hit1) ? idx1 + SEL_W'(1) : SEL_W'(FWD_RF);
        sel2_d = (issue && bus.fwd_enable && hit2) ? idx2 + SEL_W'(1) : SEL_W'(FWD_RF);

        cnt_d = (stall && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q   <= '0;
            sel1_q <= '0;
            sel2_q <= '0;
            cnt_q  <= '0;
        end else begin
            sb_q   <= sb_d;
            sel1_q <= sel1_d;
            sel2_q <= sel2_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.stall       = stall;
    assign bus.fwd_sel1    = sel1_q;
    assign bus.fwd_sel2    = sel2_q;
    assign bus.stall_count = cnt_q;

endmodule
